// File: rtl/bram_pkg.sv
// Shared types and constants for the feature-map BRAM read path.
package bram_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;

    localparam int BRAM_RD_LAT = 1;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that absorbs BRAM read data while the downstream stalls.
module skid_fifo2 #(
    parameter int unsigned W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   occ,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign occ   = cnt;
    assign empty = (cnt == 2'd0);

endmodule

// File: rtl/bram_stream_reader.sv
// Sequences reads from BRAM port B and streams the words out with valid/ready,
// using a credit check so the 2-entry FIFO can never overflow.
module bram_stream_reader
    import bram_pkg::*;
#(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW:0]          len,
    output logic                 busy,
    output logic                 done,
    output logic                 b_en,
    output logic [AW-1:0]        b_addr,
    input  logic signed [DW-1:0] b_dout,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_data,
    output logic                 m_last
);

    localparam int unsigned LW      = AW + 1;
    localparam int unsigned CREDITS = BRAM_RD_LAT + 1;

    rd_state_t     state;
    rd_state_t     state_nxt;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] issued_q;
    logic          inflight_q;
    logic          last_inflight_q;
    logic          done_q;

    logic [DW:0]   fifo_dout;
    logic [1:0]    fifo_occ;
    logic          fifo_empty;
    logic          pop;
    logic          head_last;
    logic          last_issue;
    logic          credit_ok;
    logic [2:0]    pending;

    assign m_valid    = !fifo_empty;
    assign pop        = m_valid && m_ready;
    assign head_last  = fifo_dout[DW];
    assign last_issue = (issued_q == len_q - LW'(1));

    // Words already owed to the FIFO after this cycle's pop must leave room for one more.
    assign pending   = {2'b00, inflight_q} + {1'b0, fifo_occ} - {2'b00, pop};
    assign credit_ok = (pending < 3'(CREDITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && (len != '0)) state_nxt = RUN;
            RUN:     if (b_en && last_issue)   state_nxt = DRAIN;
            DRAIN:   if (pop && head_last)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        b_en = 1'b0;
        busy = 1'b0;
        case (state)
            RUN: begin
                b_en = credit_ok;
                busy = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            default: ;
        endcase
    end

    // Address/issue counters, read-latency tracking and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            last_inflight_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            if ((state == IDLE) && start && (len != '0)) begin
                addr_q   <= base_addr;
                len_q    <= len;
                issued_q <= '0;
            end else if (b_en) begin
                addr_q   <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
                issued_q <= issued_q + LW'(1);
            end
            inflight_q      <= b_en;
            last_inflight_q <= b_en && last_issue;
            done_q          <= ((state == IDLE) && start && (len == '0)) ||
                               ((state == DRAIN) && pop && head_last);
        end
    end

    skid_fifo2 #(.W(DW + 1)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   ({last_inflight_q, b_dout}),
        .pop   (pop),
        .dout  (fifo_dout),
        .occ   (fifo_occ),
        .empty (fifo_empty)
    );

    assign b_addr = addr_q;
    assign done   = done_q;
    assign m_data = fifo_dout[DW-1:0];
    assign m_last = head_last && m_valid;

endmodule
